cdc_handshake_arbiter: RTL
==========================

Name: cdc_handshake_arbiter

Overview:
- Shares one four-phase handshake crossing channel between N_REQ requesters in the source clock domain.
- Arbitrates round-robin, drives stb_o to the crossing and synchronises the returning ack_i.
- Sequences the full four-phase cycle, then signals completion to the winning requester.
- Sits in front of the crossing; the data mux is driven by sel_o.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- SEL_BITS, 2, width of sel_o; must be at least clog2(N_REQ)
- ACK_SYNC, 2, flop stages on ack_i before use (minimum 2)
- TIMEOUT, 255, cycles allowed per handshake phase (timeout feature only)
- TIMEOUT_BITS, 8, counter width for TIMEOUT

Ports:
- clk  in  1  single clock (source domain)
- rst  in  1  asynchronous, active-high reset
- req_i  in  N_REQ  level request per requester; held until its done_o
- grant_o  out  N_REQ  one-hot owner of the channel, held for the whole transaction
- sel_o  out  SEL_BITS  binary index of the current owner, for the data mux
- done_o  out  N_REQ  one-cycle completion pulse to the owner
- stb_o  out  1  strobe to the crossing, registered
- ack_i  in  1  raw acknowledge from the destination domain
- busy_o  out  1  high in any state other than IDLE
- err_o  out  1  one-cycle timeout pulse; constant 0 without the optional feature

Behaviour:
- Reset (async, immediate), all registers cleared:
  - state=IDLE; grant_o=0, sel_o=0, done_o=0, stb_o=0, busy_o=0, err_o=0.
  - Round-robin pointer=0; synchroniser flops=0.
- ack_s is ack_i after ACK_SYNC flops. It is the only ack used internally.
- Pick rule: the first asserted req_i at index ptr, ptr+1, ... wrapping modulo N_REQ.
- States:
  - IDLE:
    - if |req_i at edge k, then after edge k: grant_o=onehot(pick), sel_o=pick, stb_o=1, state=REQ.
    - Otherwise stay in IDLE.
  - REQ: hold stb_o=1 until ack_s=1. On that edge stb_o=0, state=REL.
  - REL:
    - wait for ack_s=0. On that edge: done_o[owner]=1 for one cycle, grant_o=0, ptr=(owner+1) mod N_REQ, state=IDLE.
- Latency:
  - req to stb_o: 1 cycle.
  - Total transaction: 1 + 2*ACK_SYNC cycles plus the destination-side delays.
  - At least one IDLE cycle between consecutive transactions.
- Ownership: grant_o, sel_o and ptr are frozen outside IDLE. New requests arriving mid-transaction wait.
- Owner drops req_i mid-transaction: no abort. The handshake completes and done_o still pulses. A requester may not re-request in the cycle done_o is high.
- Simultaneous requests: the winner comes from ptr. With ptr=0 and req_i=4'b1010, the grant goes to index 1.
- ack_s=1 while in IDLE (stale ack): ignored. The arbiter stays in IDLE and grants nothing until ack_s=0.
- Reset asserted mid-transaction: stb_o drops immediately. The crossing recovers through its own reset.

Optional Feature:
Macro: CDC_ARB_TIMEOUT_EN
- With the macro:
  - A phase counter is cleared on entering REQ or REL and increments each cycle in those states.
  - Reaching TIMEOUT in REQ: stb_o=0, err_o pulses one cycle, state=REL. The ack is still drained.
  - Reaching TIMEOUT in REL: err_o pulses, grant_o=0, ptr advances, state=IDLE, and done_o is NOT asserted.
- Without the macro: no counter, err_o tied to 0, and the arbiter waits indefinitely.

Decomposition:
- Package cdc_arb_pkg holds:
  - state encoding IDLE=2'd0, REQ=2'd1, REL=2'd2;
  - the default widths.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector and ptr.
  - Outputs: valid, one-hot grant and binary index.
  - Reused by other arbiters.
- ack synchroniser: existing single-bit pipeline register at depth ACK_SYNC; no new module.

Test Plan:
1. Reset then req_i=4'b0001, ack model returns ack 3 cycles after stb and drops it 3 cycles after stb falls:
   - grant_o=0001 and stb_o=1 one cycle after req;
   - done_o=0001 pulses once; busy_o returns to 0.
2. req_i=4'b1111 held, for 8 transactions: grant order 0,1,2,3,0,1,2,3 with no index skipped.
3. ptr=2 (after serving index 1), req_i=4'b0011: grant goes to index 0, then index 1.
4. Owner 3 drops req_i one cycle after its grant: stb and ack cycle completes, done_o[3] pulses, next grant proceeds normally.
5. ack_i forced to 1 before any request: no grant while ack_s=1. Release ack: the grant follows within 1+ACK_SYNC cycles.
6. (CDC_ARB_TIMEOUT_EN, TIMEOUT=16) ack_i stuck at 0:
   - stb_o falls after 16 cycles in REQ and err_o pulses once;
   - REL exits immediately because ack_s=0; no done_o.
   - Then assert rst mid-REQ: all outputs 0 asynchronously.

Source files
------------

// File: rtl/cdc_arb_pkg.sv
// Shared types and default widths for the handshake-crossing arbiter.
// State encoding is fixed so the crossing can be probed from outside.
package cdc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } arb_state_t;

    localparam int N_REQ_DEF        = 4;
    localparam int SEL_BITS_DEF     = 2;
    localparam int ACK_SYNC_DEF     = 2;
    localparam int TIMEOUT_DEF      = 255;
    localparam int TIMEOUT_BITS_DEF = 8;

endpackage

// File: rtl/cdc_handshake_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at ptr, ptr+1, ...
// wrapping modulo N_REQ. Shared with other arbiters.
module rr_pick #(
    parameter int N_REQ    = 4,
    parameter int SEL_BITS = 2
) (
    input  logic [N_REQ-1:0]    req,
    input  logic [SEL_BITS-1:0] ptr,
    output logic                valid,
    output logic [N_REQ-1:0]    grant,
    output logic [SEL_BITS-1:0] idx
);

    // Scan from the farthest offset down so the nearest one wins.
    always_comb begin
        logic [N_REQ-1:0] cand;
        int j;
        cand  = '0;
        j     = 0;
        valid = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j    = (int'(ptr) + i) % N_REQ;
            cand = N_REQ'(1) << j;
            if (|(req & cand)) begin
                valid = 1'b1;
                grant = cand;
                idx   = SEL_BITS'(j);
            end
        end
    end

endmodule

// File: rtl/cdc_handshake_arbiter.sv
// Round-robin owner of one four-phase crossing channel.
// Optional per-phase timeout enabled by CDC_ARB_TIMEOUT_EN.
module cdc_handshake_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEF,
    parameter int SEL_BITS     = SEL_BITS_DEF,
    parameter int ACK_SYNC     = ACK_SYNC_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF,
    parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_i,
    output logic [N_REQ-1:0]    grant_o,
    output logic [SEL_BITS-1:0] sel_o,
    output logic [N_REQ-1:0]    done_o,
    output logic                stb_o,
    input  logic                ack_i,
    output logic                busy_o,
    output logic                err_o
);

    arb_state_t state_q, state_n;
    logic [N_REQ-1:0]    grant_q, grant_n;
    logic [SEL_BITS-1:0] sel_q, sel_n;
    logic [SEL_BITS-1:0] ptr_q, ptr_n, ptr_adv;
    logic [N_REQ-1:0]    done_q, done_n;
    logic                stb_q, stb_n;
    logic [ACK_SYNC-1:0] ack_sync_q;
    logic                ack_s;

    logic                pick_valid;
    logic [N_REQ-1:0]    pick_grant;
    logic [SEL_BITS-1:0] pick_idx;

`ifdef CDC_ARB_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] cnt_q, cnt_n;
    logic                    tmo_q, tmo_n;
    logic                    err_q, err_n;
    logic                    tmo_hit;

    assign tmo_hit = (cnt_q == TIMEOUT_BITS'(TIMEOUT - 1));
`else
    logic [TIMEOUT_BITS-1:0] unused_tmo;

    assign unused_tmo = TIMEOUT_BITS'(TIMEOUT);
`endif

    rr_pick #(
        .N_REQ    (N_REQ),
        .SEL_BITS (SEL_BITS)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign ack_s   = ack_sync_q[ACK_SYNC-1];
    assign ptr_adv = (int'(sel_q) >= N_REQ - 1) ? '0 : sel_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            ptr_q      <= '0;
            done_q     <= '0;
            stb_q      <= 1'b0;
            ack_sync_q <= '0;
`ifdef CDC_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_n;
            grant_q    <= grant_n;
            sel_q      <= sel_n;
            ptr_q      <= ptr_n;
            done_q     <= done_n;
            stb_q      <= stb_n;
            ack_sync_q <= {ack_sync_q[ACK_SYNC-2:0], ack_i};
`ifdef CDC_ARB_TIMEOUT_EN
            cnt_q      <= cnt_n;
            tmo_q      <= tmo_n;
            err_q      <= err_n;
`endif
        end
    end

    // A stale ack_s in IDLE blocks new grants until the crossing settles.
    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        sel_n   = sel_q;
        ptr_n   = ptr_q;
        stb_n   = stb_q;
        done_n  = '0;
`ifdef CDC_ARB_TIMEOUT_EN
        tmo_n   = tmo_q;
        err_n   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef CDC_ARB_TIMEOUT_EN
                tmo_n = 1'b0;
`endif
                if (pick_valid && !ack_s) begin
                    grant_n = pick_grant;
                    sel_n   = pick_idx;
                    stb_n   = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    stb_n   = 1'b0;
                    state_n = REL;
                end
`ifdef CDC_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    stb_n   = 1'b0;
                    err_n   = 1'b1;
                    tmo_n   = 1'b1;
                    state_n = REL;
                end
`endif
            end
            REL: begin
                if (!ack_s) begin
`ifdef CDC_ARB_TIMEOUT_EN
                    if (!tmo_q) done_n = grant_q;
`else
                    done_n = grant_q;
`endif
                    grant_n = '0;
                    ptr_n   = ptr_adv;
                    state_n = IDLE;
                end
`ifdef CDC_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_n   = 1'b1;
                    grant_n = '0;
                    ptr_n   = ptr_adv;
                    state_n = IDLE;
                end
`endif
            end
            default: begin
                stb_n   = 1'b0;
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
`ifdef CDC_ARB_TIMEOUT_EN
        if (state_q == IDLE || state_n != state_q) cnt_n = '0;
        else cnt_n = cnt_q + 1'b1;
`endif
    end

    always_comb begin
        grant_o = grant_q;
        sel_o   = sel_q;
        done_o  = done_q;
        stb_o   = stb_q;
        busy_o  = (state_q != IDLE);
`ifdef CDC_ARB_TIMEOUT_EN
        err_o   = err_q;
`else
        err_o   = 1'b0;
`endif
    end

endmodule
